// File: rtl/bus_arbiter.sv
// Fixed-priority bus arbiter: the highest requesting index wins, and the grant is held until
// done, owner release or a hold timeout, followed by one turnaround cycle.
module bus_arbiter #(
    parameter int unsigned N_REQ     = 4,
    parameter int unsigned ID_WIDTH  = (N_REQ > 1) ? $clog2(N_REQ) : 1,
    parameter int unsigned MAX_HOLD  = 8,
    parameter int unsigned CNT_WIDTH = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ-1:0]    req,
    input  logic                done,
    output logic [N_REQ-1:0]    gnt,
    output logic [ID_WIDTH-1:0] gnt_id,
    output logic                gnt_valid,
    output logic                timeout
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StBusy = 2'd1;
    localparam logic [1:0] StGap  = 2'd2;

    logic [1:0]           state_q, state_d;
    logic [N_REQ-1:0]     gnt_q, gnt_d;
    logic [ID_WIDTH-1:0]  gnt_id_q, gnt_id_d;
    logic                 gnt_valid_q, gnt_valid_d;
    logic                 timeout_q, timeout_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [N_REQ-1:0]     mask_q, mask_d;

    logic [N_REQ-1:0]     masked_req;
    logic [N_REQ-1:0]     cand_req;
    logic [ID_WIDTH-1:0]  winner;

    // Ascending scan, so the last (highest) set bit is the result.
    function automatic logic [ID_WIDTH-1:0] highest_set(input logic [N_REQ-1:0] v);
        logic [ID_WIDTH-1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (v[i]) idx = ID_WIDTH'(i);
        end
        return idx;
    endfunction

    // The mask only defers a timed-out owner; it never blocks a sole requester.
    assign masked_req = req & ~mask_q;
    assign cand_req   = (|masked_req) ? masked_req : req;
    assign winner     = highest_set(cand_req);

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        gnt_id_d    = gnt_id_q;
        gnt_valid_d = gnt_valid_q;
        timeout_d   = timeout_q;
        cnt_d       = cnt_q;
        mask_d      = mask_q;
        case (state_q)
            StIdle: begin
                if (|req) begin
                    state_d     = StBusy;
                    gnt_d       = N_REQ'(1) << winner;
                    gnt_id_d    = winner;
                    gnt_valid_d = 1'b1;
                    cnt_d       = '0;
                    mask_d      = '0;
                end
            end
            StBusy: begin
                if (done || !req[gnt_id_q] || (cnt_q == CNT_WIDTH'(MAX_HOLD - 1))) begin
                    state_d     = StGap;
                    gnt_d       = '0;
                    gnt_id_d    = '0;
                    gnt_valid_d = 1'b0;
                    cnt_d       = '0;
                    // A normal release wins over a coincident hold expiry.
                    if (!done && req[gnt_id_q]) begin
                        timeout_d = 1'b1;
                        mask_d    = N_REQ'(1) << gnt_id_q;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            StGap: begin
                state_d   = StIdle;
                timeout_d = 1'b0;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            gnt_q       <= '0;
            gnt_id_q    <= '0;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
            cnt_q       <= '0;
            mask_q      <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            gnt_id_q    <= gnt_id_d;
            gnt_valid_q <= gnt_valid_d;
            timeout_q   <= timeout_d;
            cnt_q       <= cnt_d;
            mask_q      <= mask_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_id    = gnt_id_q;
    assign gnt_valid = gnt_valid_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed and randomized bench for bus_arbiter, checked every cycle against a
// transaction-level model of owner, hold length, turnaround and deferred index.
module tb_bus_arbiter;

    localparam int N_REQ    = 4;
    localparam int MAX_HOLD = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       gnt_valid;
    logic       timeout;

    int checks = 0;
    int errors = 0;

    // Reference model: who owns the bus, for how many cycles, and so on.
    int owner    = -1;
    int held     = 0;
    int deferred = -1;
    bit in_gap   = 1'b0;
    bit tmo      = 1'b0;

    bus_arbiter #(
        .N_REQ   (N_REQ),
        .MAX_HOLD(MAX_HOLD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .done     (done),
        .gnt      (gnt),
        .gnt_id   (gnt_id),
        .gnt_valid(gnt_valid),
        .timeout  (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_edge(input logic r, input logic [3:0] q, input logic d);
        int w;
        if (r) begin
            owner = -1; held = 0; in_gap = 1'b0; tmo = 1'b0; deferred = -1;
        end else if (owner >= 0) begin
            if (d || !q[owner]) begin
                owner = -1; in_gap = 1'b1;
            end else if (held == MAX_HOLD) begin
                deferred = owner; tmo = 1'b1; owner = -1; in_gap = 1'b1;
            end else begin
                held++;
            end
        end else if (in_gap) begin
            in_gap = 1'b0; tmo = 1'b0;
        end else begin
            w = -1;
            for (int i = N_REQ - 1; i >= 0; i--)
                if (q[i] && i != deferred && w < 0) w = i;
            for (int i = N_REQ - 1; i >= 0; i--)
                if (q[i] && w < 0) w = i;
            if (w >= 0) begin
                owner = w; held = 1; deferred = -1;
            end
        end
    endtask

    task automatic compare_all();
        logic [3:0] eg;
        eg = '0;
        if (owner >= 0) eg[owner] = 1'b1;
        check("gnt", 32'(gnt), 32'(eg));
        check("gnt_id", 32'(gnt_id), (owner >= 0) ? 32'(owner) : 32'd0);
        check("gnt_valid", 32'(gnt_valid), (owner >= 0) ? 32'd1 : 32'd0);
        check("timeout", 32'(timeout), 32'(tmo));
    endtask

    // Drive inputs, take one edge, update the model, then sample just after the edge.
    task automatic step(input logic r, input logic [3:0] q, input logic d);
        rst = r; req = q; done = d;
        @(posedge clk);
        model_edge(r, q, d);
        #1;
        compare_all();
    endtask

    initial begin
        logic [3:0] rq;
        logic       rd;
        logic       rr;

        // Reset with everyone requesting, then highest index wins.
        step(1'b1, 4'b1111, 1'b0);
        check("rst_gnt", 32'(gnt), 32'd0);
        step(1'b1, 4'b1111, 1'b0);
        check("rst_timeout", 32'(timeout), 32'd0);
        step(1'b0, 4'b1111, 1'b0);
        check("first_gnt", 32'(gnt), 32'b1000);
        check("first_id", 32'(gnt_id), 32'd3);
        step(1'b0, 4'b0000, 1'b0);
        step(1'b0, 4'b0000, 1'b0);

        // Priority and done release.
        step(1'b0, 4'b0110, 1'b0);
        check("prio_gnt", 32'(gnt), 32'b0100);
        step(1'b0, 4'b0110, 1'b0);
        step(1'b0, 4'b0110, 1'b1);
        check("done_gap", 32'(gnt), 32'd0);
        step(1'b0, 4'b0110, 1'b0);
        step(1'b0, 4'b0110, 1'b0);
        check("regrant", 32'(gnt), 32'b0100);
        step(1'b0, 4'b0000, 1'b0);
        step(1'b0, 4'b0000, 1'b0);

        // Owner drops its request in the third busy cycle.
        step(1'b0, 4'b0010, 1'b0);
        step(1'b0, 4'b0010, 1'b0);
        step(1'b0, 4'b0010, 1'b0);
        step(1'b0, 4'b0000, 1'b0);
        check("drop_gnt", 32'(gnt), 32'd0);
        check("drop_no_tmo", 32'(timeout), 32'd0);
        step(1'b0, 4'b0000, 1'b0);

        // Timeout fairness.
        step(1'b0, 4'b1001, 1'b0);
        for (int i = 0; i < 7; i++) step(1'b0, 4'b1001, 1'b0);
        check("hold8_gnt", 32'(gnt), 32'b1000);
        step(1'b0, 4'b1001, 1'b0);
        check("tmo_pulse", 32'(timeout), 32'd1);
        check("tmo_gnt", 32'(gnt), 32'd0);
        step(1'b0, 4'b1001, 1'b0);
        check("tmo_clear", 32'(timeout), 32'd0);
        step(1'b0, 4'b1001, 1'b0);
        check("fair_gnt", 32'(gnt), 32'b0001);
        step(1'b0, 4'b1001, 1'b1);
        step(1'b0, 4'b1001, 1'b0);
        step(1'b0, 4'b1001, 1'b0);
        check("unmask_gnt", 32'(gnt), 32'b1000);

        // Done coincident with the last allowed hold cycle.
        for (int i = 0; i < 7; i++) step(1'b0, 4'b1001, 1'b0);
        step(1'b0, 4'b1001, 1'b1);
        check("coinc_no_tmo", 32'(timeout), 32'd0);
        step(1'b0, 4'b1001, 1'b0);
        step(1'b0, 4'b1001, 1'b0);
        check("coinc_no_mask", 32'(gnt), 32'b1000);
        step(1'b0, 4'b1001, 1'b1);
        step(1'b0, 4'b0000, 1'b0);

        // Sole requester times out and is granted again; reset mid-grant.
        step(1'b0, 4'b0100, 1'b0);
        for (int i = 0; i < 7; i++) step(1'b0, 4'b0100, 1'b0);
        step(1'b0, 4'b0100, 1'b0);
        check("sole_tmo", 32'(timeout), 32'd1);
        step(1'b0, 4'b0100, 1'b0);
        step(1'b0, 4'b0100, 1'b0);
        check("sole_regrant", 32'(gnt), 32'b0100);
        step(1'b0, 4'b0100, 1'b0);
        step(1'b1, 4'b0100, 1'b0);
        check("rst_mid_gnt", 32'(gnt), 32'd0);
        check("rst_mid_valid", 32'(gnt_valid), 32'd0);
        step(1'b0, 4'b0000, 1'b0);

        // Randomized traffic with sticky requests.
        rq = 4'b0000;
        for (int i = 0; i < 600; i++) begin
            for (int b = 0; b < N_REQ; b++)
                if ($urandom_range(0, 3) == 0) rq[b] = ~rq[b];
            rd = ($urandom_range(0, 9) == 0);
            rr = ($urandom_range(0, 149) == 0);
            step(rr, rq, rd);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
